rle_decompressor: RTL and testbench

//  Upstream stage of the coordinator's image load path. Accepts 16-bit run-length-encoded words from the file-feed side.

---
 rtl/rle_decompressor.sv | 134 +++++++++++++
 tb/tb_rle_decompressor.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decompressor.sv
// Run-length decoder feeding the image RAM through a request/ack write handshake.
// Optional build macro RLE_CHECKSUM_EN adds a 16-bit running sum of acknowledged pixels.
module rle_decompressor #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 65536
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic              interrupt,
    input  logic [15:0]       Din,
    input  logic              dinValid,
    output logic              dinReady,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [DATA_W-1:0] ramDataOut,
    output logic              ramWriteSignal,
    input  logic              ramDoneWrite,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef RLE_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic [ADDR_W:0]   pixCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              write_reg;
    logic [7:0]        remaining_reg;
    logic [ADDR_W:0]   count_reg;
    logic              err_reg;
`ifdef RLE_CHECKSUM_EN
    logic [15:0]       sum_reg;
`endif

    logic [7:0]  run_len;
    logic [31:0] run_end;
    logic        run_overflow;

    // A run is rejected whole if its last pixel would land beyond the image limit.
    assign run_len      = Din[15:8];
    assign run_end      = 32'(count_reg) + 32'(run_len);
    assign run_overflow = run_end > 32'(MAX_BYTES);

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            write_reg     <= 1'b0;
            remaining_reg <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
`ifdef RLE_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else if (interrupt) begin
            // Counters and err stay put so the aborted image can be inspected.
            state_reg <= S_IDLE;
            write_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    state_reg <= S_IDLE;
                    if (start) begin
                        state_reg <= S_FETCH;
                        base_reg  <= baseAddr;
                        count_reg <= '0;
                        err_reg   <= 1'b0;
`ifdef RLE_CHECKSUM_EN
                        sum_reg   <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (dinValid) begin
                        if (run_len == 8'd0) begin
                            state_reg <= S_DONE;
                        end else if (run_overflow) begin
                            err_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            data_reg      <= DATA_W'(Din[7:0]);
                            remaining_reg <= run_len;
                            state_reg     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    addr_reg  <= base_reg + count_reg[ADDR_W-1:0];
                    write_reg <= 1'b1;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (ramDoneWrite) begin
                        write_reg     <= 1'b0;
                        count_reg     <= count_reg + (ADDR_W+1)'(1);
                        remaining_reg <= remaining_reg - 8'd1;
`ifdef RLE_CHECKSUM_EN
                        sum_reg       <= sum_reg + 16'(data_reg);
`endif
                        state_reg     <= (remaining_reg == 8'd1) ? S_FETCH : S_WRITE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign dinReady       = (state_reg == S_FETCH);
    assign busy           = (state_reg == S_FETCH) || (state_reg == S_WRITE) || (state_reg == S_WAIT);
    assign done           = (state_reg == S_DONE);
    assign ramAddress     = addr_reg;
    assign ramDataOut     = data_reg;
    assign ramWriteSignal = write_reg;
    assign err            = err_reg;
    assign pixCount       = count_reg;
`ifdef RLE_CHECKSUM_EN
    assign checksum       = sum_reg;
`endif

endmodule

// File: tb/tb_rle_decompressor.sv
// Self-checking bench for rle_decompressor: RAM responder with programmable ack delay,
// image-level reference model computing the expected write list, pixel count, err and checksum.
module tb_rle_decompressor;

    localparam int MAXB = 40;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [15:0] baseAddr = '0;
    logic        interrupt = 1'b0;
    logic [15:0] Din = '0;
    logic        dinValid = 1'b0;
    logic        dinReady;
    logic [15:0] ramAddress;
    logic [7:0]  ramDataOut;
    logic        ramWriteSignal;
    logic        ramDoneWrite = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [16:0] pixCount;
`ifdef RLE_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    rle_decompressor #(.ADDR_W(16), .DATA_W(8), .MAX_BYTES(MAXB)) dut (
        .clk(clk), .RST(RST), .start(start), .baseAddr(baseAddr), .interrupt(interrupt),
        .Din(Din), .dinValid(dinValid), .dinReady(dinReady),
        .ramAddress(ramAddress), .ramDataOut(ramDataOut), .ramWriteSignal(ramWriteSignal),
        .ramDoneWrite(ramDoneWrite), .busy(busy), .done(done), .err(err),
`ifdef RLE_CHECKSUM_EN
        .checksum(checksum),
`endif
        .pixCount(pixCount)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int fail_cnt = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int stab_err = 0;
    int rdy_err = 0;
    int done_cnt = 0;
    logic [15:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    logic [15:0] held_addr;
    logic [7:0]  held_data;

    // RAM side: acks each request after ack_delay cycles and records what was written.
    initial forever begin
        @(posedge clk); #1;
        ramDoneWrite = 1'b0;
        if (done) done_cnt++;
        if (ramWriteSignal && dinReady) rdy_err++;
        if (!RST || !ramWriteSignal) begin
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) begin
                held_addr = ramAddress;
                held_data = ramDataOut;
            end else if (ramAddress !== held_addr || ramDataOut !== held_data) begin
                stab_err++;
            end
            if (wait_cnt >= ack_delay) begin
                ramDoneWrite = 1'b1;
                obs_addr.push_back(ramAddress);
                obs_data.push_back(ramDataOut);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Reference: expands the word list into the writes one image should produce.
    task automatic model_image(input logic [15:0] base, input logic [15:0] words[$],
                               output logic [15:0] ea[$], output logic [7:0] ed[$],
                               output int cnt, output bit e, output int acc, output logic [15:0] sum);
        int len;
        ea = {}; ed = {}; cnt = 0; e = 0; acc = 0; sum = '0;
        foreach (words[i]) begin
            len = int'(words[i][15:8]);
            acc++;
            if (len == 0) break;
            if (cnt + len > MAXB) begin
                e = 1;
                break;
            end
            for (int k = 0; k < len; k++) begin
                ea.push_back(base + 16'(cnt));
                ed.push_back(words[i][7:0]);
                sum = sum + 16'(words[i][7:0]);
                cnt++;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] base);
        baseAddr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int budget, output bit ok);
        ok = 0;
        Din = w;
        dinValid = 1'b1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (dinReady) ok = 1;
            @(posedge clk); #1;
        end
        dinValid = 1'b0;
    endtask

    task automatic settle(output bit ok);
        for (int i = 0; i < 3000 && busy; i++) begin
            @(posedge clk); #1;
        end
        ok = !busy;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [15:0] base, input logic [15:0] words[$], input int n, output bit ok);
        bit w_ok;
        bit s_ok;
        ok = 1;
        obs_addr = {}; obs_data = {};
        done_cnt = 0; stab_err = 0; rdy_err = 0;
        do_start(base);
        for (int i = 0; i < n && ok; i++) begin
            send_word(words[i], 3000, w_ok);
            if (!w_ok) ok = 0;
        end
        settle(s_ok);
        if (!s_ok) ok = 0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++;
        if ({dinReady, ramWriteSignal, busy, done, err} !== 5'b0 || ramAddress !== 16'h0 ||
            ramDataOut !== 8'h0 || pixCount !== 17'h0) begin
            fail_cnt++;
            $display("FAIL reset_state: rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h cnt=%0d, required all 0",
                     dinReady, ramWriteSignal, busy, done, err, ramAddress, ramDataOut, pixCount);
        end
        RST = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok;
        bit bad;
        ack_delay = 0;
        obs_addr = {}; obs_data = {}; done_cnt = 0;
        do_start(16'h0100);
        Din = 16'h03AA;
        dinValid = 1'b1;
        cmp_cnt++;
        if (dinReady !== 1'b1) begin
            fail_cnt++;
            $display("FAIL basic_ready: dinReady=%b, required 1", dinReady);
        end
        @(posedge clk); #1;
        dinValid = 1'b0;
        cmp_cnt++;
        if (ramWriteSignal !== 1'b0 || busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL basic_setup: wr=%b busy=%b, required 0/1", ramWriteSignal, busy);
        end
        @(posedge clk); #1;
        cmp_cnt++;
        if (ramWriteSignal !== 1'b1 || ramAddress !== 16'h0100 || ramDataOut !== 8'hAA) begin
            fail_cnt++;
            $display("FAIL basic_first_req: wr=%b addr=%h data=%h, required 1/0100/aa",
                     ramWriteSignal, ramAddress, ramDataOut);
        end
        send_word(16'h0000, 3000, ok);
        settle(ok);
        bad = (obs_addr.size() != 3);
        if (!bad) foreach (obs_addr[i]) if (obs_addr[i] !== 16'h0100 + 16'(i) || obs_data[i] !== 8'hAA) bad = 1;
        cmp_cnt++;
        if (bad || !ok) begin
            fail_cnt++;
            $display("FAIL basic_writes: %0d writes, required 3 of aa at 0100..0102", obs_addr.size());
        end
        cmp_cnt++;
        if (done_cnt !== 1 || pixCount !== 17'd3 || err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL basic_end: done pulses=%0d cnt=%0d err=%b, required 1/3/0", done_cnt, pixCount, err);
        end
        $display("basic: base=0100 run {3,aa} writes=%0d pixCount=%0d", obs_addr.size(), pixCount);
    endtask

    task automatic test_slow_ack;
        logic [15:0] w[$];
        logic [15:0] ea[$];
        logic [7:0]  ed[$];
        logic [15:0] base;
        logic [15:0] sum;
        int cnt, acc;
        bit e, ok, bad;
        ack_delay = 5;
        base = 16'($urandom);
        w = '{{8'($urandom_range(2, 6)), 8'($urandom)}, 16'h0000};
        model_image(base, w, ea, ed, cnt, e, acc, sum);
        play(base, w, acc, ok);
        bad = !ok || (obs_addr.size() != ea.size());
        if (!bad) foreach (ea[i]) if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) bad = 1;
        cmp_cnt++;
        if (bad) begin
            fail_cnt++;
            $display("FAIL slow_writes: %0d writes, required %0d", obs_addr.size(), ea.size());
        end
        cmp_cnt++;
        if (stab_err !== 0 || rdy_err !== 0) begin
            fail_cnt++;
            $display("FAIL slow_stable: unstable cycles=%0d ready-while-writing=%0d, required 0/0", stab_err, rdy_err);
        end
        cmp_cnt++;
        if (pixCount !== 17'(cnt)) begin
            fail_cnt++;
            $display("FAIL slow_count: pixCount=%0d, required %0d", pixCount, cnt);
        end
        $display("slow_ack: base=%h word=%h writes=%0d", base, w[0], obs_addr.size());
    endtask

    task automatic test_wrap;
        logic [15:0] w[$];
        bit ok, bad;
        logic [15:0] exp_a[4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        ack_delay = 1;
        w = '{16'h0411, 16'h0000};
        play(16'hFFFE, w, 2, ok);
        bad = !ok || (obs_addr.size() != 4);
        if (!bad) foreach (exp_a[i]) if (obs_addr[i] !== exp_a[i] || obs_data[i] !== 8'h11) bad = 1;
        cmp_cnt++;
        if (bad) begin
            fail_cnt++;
            $display("FAIL wrap_writes: %0d writes (first %h), required FFFE,FFFF,0000,0001",
                     obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 16'h0);
        end
        cmp_cnt++;
        if (pixCount !== 17'd4) begin
            fail_cnt++;
            $display("FAIL wrap_count: pixCount=%0d, required 4", pixCount);
        end
        $display("wrap: base=FFFE run {4,11} writes=%0d pixCount=%0d", obs_addr.size(), pixCount);
    endtask

    task automatic test_overflow;
        logic [15:0] w[$];
        bit ok, bad;
        ack_delay = 0;
        w = '{16'h1E5A, 16'h0FC3};
        play(16'h2000, w, 2, ok);
        bad = !ok || (obs_addr.size() != 30);
        if (!bad) foreach (obs_data[i]) if (obs_data[i] !== 8'h5A) bad = 1;
        cmp_cnt++;
        if (bad) begin
            fail_cnt++;
            $display("FAIL ovf_writes: %0d writes, required 30 of 5a", obs_addr.size());
        end
        cmp_cnt++;
        if (err !== 1'b1 || done_cnt !== 1 || pixCount !== 17'd30) begin
            fail_cnt++;
            $display("FAIL ovf_flags: err=%b done pulses=%0d cnt=%0d, required 1/1/30", err, done_cnt, pixCount);
        end
        send_word(16'h0133, 5, ok);
        cmp_cnt++;
        if (ok || obs_addr.size() != 30) begin
            fail_cnt++;
            $display("FAIL ovf_after: accepted=%b writes=%0d, required 0/30", ok, obs_addr.size());
        end
        // Exactly filling the image is legal; the new start also clears err.
        w = '{16'h19A1, 16'h0FB2, 16'h0000};
        play(16'h3000, w, 3, ok);
        cmp_cnt++;
        if (!ok || err !== 1'b0 || pixCount !== 17'(MAXB) || obs_addr.size() != MAXB || done_cnt !== 1) begin
            fail_cnt++;
            $display("FAIL ovf_exact: err=%b cnt=%0d writes=%0d done=%0d, required 0/%0d/%0d/1",
                     err, pixCount, obs_addr.size(), done_cnt, MAXB, MAXB);
        end
        $display("overflow: 30+15 rejected, 25+15 accepted, err=%b pixCount=%0d", err, pixCount);
    endtask

    task automatic test_interrupt;
        bit ok;
        ack_delay = 3;
        obs_addr = {}; obs_data = {}; done_cnt = 0;
        do_start(16'h0400);
        send_word(16'h0422, 100, ok);
        for (int i = 0; i < 200 && obs_addr.size() < 1; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 200 && ramWriteSignal; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 200 && !ramWriteSignal; i++) begin @(posedge clk); #1; end
        cmp_cnt++;
        if (!ok || ramWriteSignal !== 1'b1 || obs_addr.size() != 1) begin
            fail_cnt++;
            $display("FAIL irq_reach: wr=%b writes=%0d, required second request pending", ramWriteSignal, obs_addr.size());
        end
        interrupt = 1'b1;
        @(posedge clk); #1;
        interrupt = 1'b0;
        cmp_cnt++;
        if (ramWriteSignal !== 1'b0 || busy !== 1'b0 || dinReady !== 1'b0 || pixCount !== 17'd1) begin
            fail_cnt++;
            $display("FAIL irq_abort: wr=%b busy=%b rdy=%b cnt=%0d, required 0/0/0/1",
                     ramWriteSignal, busy, dinReady, pixCount);
        end
        // start together with interrupt must not launch a new image.
        baseAddr = 16'h0500;
        start = 1'b1;
        interrupt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        interrupt = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cmp_cnt++;
        if (busy !== 1'b0 || done_cnt !== 0 || obs_addr.size() != 1 || pixCount !== 17'd1) begin
            fail_cnt++;
            $display("FAIL irq_idle: busy=%b done pulses=%0d writes=%0d cnt=%0d, required 0/0/1/1",
                     busy, done_cnt, obs_addr.size(), pixCount);
        end
        $display("interrupt: aborted {4,22} after %0d write(s), pixCount=%0d", obs_addr.size(), pixCount);
    endtask

    task automatic test_random;
        logic [15:0] w[$];
        logic [15:0] ea[$];
        logic [7:0]  ed[$];
        logic [15:0] base;
        logic [15:0] sum;
        int cnt, acc;
        bit e, ok, bad;
        for (int img = 0; img < 8; img++) begin
            ack_delay = $urandom_range(0, 3);
            base = 16'($urandom);
            w = {};
            for (int r = 0; r < int'($urandom_range(1, 4)); r++)
                w.push_back({8'($urandom_range(0, 14)), 8'($urandom)});
            w.push_back(16'h0000);
            model_image(base, w, ea, ed, cnt, e, acc, sum);
            play(base, w, acc, ok);
            bad = !ok || (obs_addr.size() != ea.size());
            if (!bad) foreach (ea[i]) if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) bad = 1;
            cmp_cnt++;
            if (bad) begin
                fail_cnt++;
                $display("FAIL rand_writes[%0d]: %0d writes, required %0d", img, obs_addr.size(), ea.size());
            end
            cmp_cnt++;
            if (pixCount !== 17'(cnt) || err !== e || done_cnt !== 1) begin
                fail_cnt++;
                $display("FAIL rand_status[%0d]: cnt=%0d err=%b done=%0d, required %0d/%b/1",
                         img, pixCount, err, done_cnt, cnt, e);
            end
`ifdef RLE_CHECKSUM_EN
            cmp_cnt++;
            if (checksum !== sum) begin
                fail_cnt++;
                $display("FAIL rand_checksum[%0d]: %h, required %h", img, checksum, sum);
            end
`endif
            $display("random[%0d]: base=%h runs=%0d writes=%0d err=%b delay=%0d",
                     img, base, w.size(), obs_addr.size(), err, ack_delay);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] wa[$];
        logic [15:0] wb[$];
        logic [15:0] ea[$];
        logic [7:0]  ed[$];
        logic [15:0] eb_a[$];
        logic [7:0]  eb_d[$];
        logic [15:0] sum;
        int cnt, cnt_b, acc;
        bit e, ok, ok2, bad;
        ack_delay = 0;
        wa = '{16'h0337, 16'h0000};
        wb = '{16'h0248, 16'h0159, 16'h0000};
        model_image(16'h0A00, wa, ea, ed, cnt, e, acc, sum);
        model_image(16'h0B00, wb, eb_a, eb_d, cnt_b, e, acc, sum);
        foreach (eb_a[i]) begin ea.push_back(eb_a[i]); ed.push_back(eb_d[i]); end
        obs_addr = {}; obs_data = {}; done_cnt = 0;
        do_start(16'h0A00);
        send_word(wa[0], 3000, ok);
        send_word(wa[1], 3000, ok2);
        ok = ok && ok2;
        // Now in the done cycle of the first image: restart immediately.
        do_start(16'h0B00);
        foreach (wb[i]) begin
            send_word(wb[i], 3000, ok2);
            ok = ok && ok2;
        end
        settle(ok2);
        bad = !ok || !ok2 || (obs_addr.size() != ea.size());
        if (!bad) foreach (ea[i]) if (obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) bad = 1;
        cmp_cnt++;
        if (bad) begin
            fail_cnt++;
            $display("FAIL b2b_writes: %0d writes, required %0d", obs_addr.size(), ea.size());
        end
        cmp_cnt++;
        if (done_cnt !== 2 || pixCount !== 17'(cnt_b)) begin
            fail_cnt++;
            $display("FAIL b2b_status: done pulses=%0d cnt=%0d, required 2/%0d", done_cnt, pixCount, cnt_b);
        end
        $display("back_to_back: restart in done cycle, writes=%0d pixCount=%0d", obs_addr.size(), pixCount);
    endtask

`ifdef RLE_CHECKSUM_EN
    task automatic test_checksum;
        logic [15:0] w[$];
        bit ok;
        ack_delay = 1;
        w = '{16'h0280, 16'h01FF, 16'h0000};
        play(16'h0040, w, 3, ok);
        cmp_cnt++;
        if (!ok || checksum !== 16'h01FF) begin
            fail_cnt++;
            $display("FAIL checksum_value: %h, required 01ff", checksum);
        end
        $display("checksum: runs {2,80},{1,ff} checksum=%h", checksum);
    endtask
`endif

    task automatic test_reset_mid_run;
        bit ok;
        ack_delay = 2;
        obs_addr = {}; obs_data = {};
        do_start(16'h0700);
        send_word(16'h0A55, 100, ok);
        for (int i = 0; i < 300 && obs_addr.size() < 2; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 200 && ramWriteSignal; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 200 && !ramWriteSignal; i++) begin @(posedge clk); #1; end
        RST = 1'b0;
        @(posedge clk); #1;
        cmp_cnt++;
        if (!ok || {dinReady, ramWriteSignal, busy, done, err} !== 5'b0 || ramAddress !== 16'h0 ||
            ramDataOut !== 8'h0 || pixCount !== 17'h0
`ifdef RLE_CHECKSUM_EN
            || checksum !== 16'h0
`endif
            ) begin
            fail_cnt++;
            $display("FAIL reset_mid: wr=%b busy=%b addr=%h data=%h cnt=%0d, required all 0",
                     ramWriteSignal, busy, ramAddress, ramDataOut, pixCount);
        end
        RST = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cmp_cnt++;
        if (busy !== 1'b0 || ramWriteSignal !== 1'b0 || pixCount !== 17'h0) begin
            fail_cnt++;
            $display("FAIL reset_mid_after: busy=%b wr=%b cnt=%0d, required 0/0/0", busy, ramWriteSignal, pixCount);
        end
        $display("reset_mid_run: reset after %0d writes, outputs cleared", obs_addr.size());
    endtask

    initial begin
        test_reset;
        test_basic;
        test_slow_ack;
        test_wrap;
        test_overflow;
        test_interrupt;
        test_random;
        test_back_to_back;
`ifdef RLE_CHECKSUM_EN
        test_checksum;
`endif
        test_reset_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
